// File: rtl/scaler_pkg.sv
// Shared definitions for the scaler control blocks (horizontal and vertical).
//   SC_FRAC_BITS  : fractional bits of a scale step (4.12 format)
//   SC_STEP_WIDTH : width of a scale step
//   SC_STEP_ONE   : unity step (1.0)
//   scaler_state_e: configuration FSM states
package scaler_pkg;

    localparam int SC_FRAC_BITS  = 12;
    localparam int SC_STEP_WIDTH = 16;
    localparam int SC_STEP_ONE   = 4096;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_PEND = 2'd2
    } scaler_state_e;

endpackage

// File: rtl/scaler_h_ctrl_div.sv
// serial_div_u: unsigned restoring divider, one quotient bit per clock.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   i_start    : load i_num/i_den and begin a NUM_W-cycle division
//   i_num      : dividend
//   i_den      : divisor (caller guarantees non-zero)
//   o_done     : high during the cycle whose edge produces the last quotient bit
//   o_quot     : quotient, valid while o_done is high
module serial_div_u #(
    parameter int NUM_W = 24,
    parameter int DEN_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [NUM_W-1:0] i_num,
    input  logic [DEN_W-1:0] i_den,
    output logic             o_done,
    output logic [NUM_W-1:0] o_quot
);

    localparam int CW = $clog2(NUM_W + 1);

    logic [CW-1:0]    r_cnt;
    logic [DEN_W:0]   r_rem;
    logic [NUM_W-1:0] r_quot;
    logic [DEN_W-1:0] r_den;

    logic [DEN_W:0]   w_rem_sh;
    logic             w_ge;
    logic [DEN_W:0]   w_rem_nxt;
    logic [NUM_W-1:0] w_quot_nxt;

    // The remainder is always below the divisor, so the shifted value fits DEN_W+1 bits.
    assign w_rem_sh   = {r_rem[DEN_W-1:0], r_quot[NUM_W-1]};
    assign w_ge       = (w_rem_sh >= {1'b0, r_den});
    assign w_rem_nxt  = w_ge ? (w_rem_sh - {1'b0, r_den}) : w_rem_sh;
    assign w_quot_nxt = {r_quot[NUM_W-2:0], w_ge};

    // Exposing the next quotient lets the caller capture the result on the final edge.
    assign o_done = (r_cnt == CW'(1));
    assign o_quot = w_quot_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_rem  <= '0;
            r_quot <= '0;
            r_den  <= '0;
        end else if (i_start) begin
            r_cnt  <= CW'(NUM_W);
            r_rem  <= '0;
            r_quot <= i_num;
            r_den  <= i_den;
        end else if (r_cnt != '0) begin
            r_cnt  <= r_cnt - CW'(1);
            r_rem  <= w_rem_nxt;
            r_quot <= w_quot_nxt;
        end
    end

endmodule

// File: rtl/scaler_h_ctrl.sv
// scaler_h_ctrl: horizontal scaler configuration controller.
// Accepts src/dst line widths, computes a rounded 4.12 step with a serial
// divider, holds it in a shadow register and commits it on a vsync rising
// edge. Also measures scaled output line length against the committed width.
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   cfg_valid/cfg_ready             : request handshake
//   cfg_src_width, cfg_dst_width    : requested input/output line widths
//   vs_i                            : vsync at scaler input (commit point)
//   hs_s, de_s                      : hsync / data enable at scaler output
//   scale_step                      : committed step to the scaler
//   busy_o, pending_o               : dividing / result waiting for vsync
//   applied_o, cfg_err_o            : commit pulse / bad request or saturation pulse
//   line_len_o, len_mismatch_o      : last line length / out-of-tolerance pulse
//
// state   | meaning
// IDLE    | no request outstanding, scale_step stable
// DIV     | serial division running, requests refused
// PEND    | shadow step valid, waiting for vsync rising edge
module scaler_h_ctrl
    import scaler_pkg::*;
#(
    parameter int WIDTH_BITS   = 12,
    parameter int FRAC_BITS    = SC_FRAC_BITS,
    parameter int STEP_WIDTH   = SC_STEP_WIDTH,
    parameter int DEFAULT_STEP = SC_STEP_ONE,
    parameter int LEN_TOL      = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [WIDTH_BITS-1:0] cfg_src_width,
    input  logic [WIDTH_BITS-1:0] cfg_dst_width,
    input  logic                  vs_i,
    input  logic                  hs_s,
    input  logic                  de_s,
    output logic [STEP_WIDTH-1:0] scale_step,
    output logic                  busy_o,
    output logic                  pending_o,
    output logic                  applied_o,
    output logic                  cfg_err_o,
    output logic [WIDTH_BITS-1:0] line_len_o,
    output logic                  len_mismatch_o
);

    localparam int NUM_W = WIDTH_BITS + FRAC_BITS;

    scaler_state_e         r_state;
    scaler_state_e         w_state_nxt;

    logic [STEP_WIDTH-1:0] r_shadow;
    logic [WIDTH_BITS-1:0] r_req_dst;
    logic [WIDTH_BITS-1:0] r_active_dst;
    logic                  r_vs;
    logic                  r_hs;
    logic [WIDTH_BITS-1:0] r_px_cnt;

    logic                  w_xfer;
    logic                  w_zero;
    logic                  w_vs_rise;
    logic                  w_hs_rise;
    logic                  w_start;
    logic                  w_commit;
    logic                  w_shadow_ld;
    logic                  w_err_set;
    logic [NUM_W-1:0]      w_num;
    logic                  w_div_done;
    logic [NUM_W-1:0]      w_div_quot;
    logic                  w_sat;
    logic [WIDTH_BITS-1:0] w_diff;

    assign cfg_ready = (r_state != ST_DIV);
    assign busy_o    = (r_state == ST_DIV);
    assign pending_o = (r_state == ST_PEND);

    assign w_xfer    = cfg_valid && cfg_ready;
    assign w_zero    = (cfg_src_width == '0) || (cfg_dst_width == '0);
    assign w_vs_rise = vs_i && !r_vs;
    assign w_hs_rise = hs_s && !r_hs;

    // (src << FRAC_BITS) + dst/2 rounds the quotient to nearest.
    assign w_num = {cfg_src_width, {FRAC_BITS{1'b0}}}
                 + {{(FRAC_BITS + 1){1'b0}}, cfg_dst_width[WIDTH_BITS-1:1]};

    assign w_sat = (w_div_quot[NUM_W-1:STEP_WIDTH] != '0);

    serial_div_u #(
        .NUM_W (NUM_W),
        .DEN_W (WIDTH_BITS)
    ) u_div (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_start),
        .i_num   (w_num),
        .i_den   (cfg_dst_width),
        .o_done  (w_div_done),
        .o_quot  (w_div_quot)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_commit    = 1'b0;
        w_shadow_ld = 1'b0;
        w_err_set   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_xfer) begin
                    if (w_zero) begin
                        w_err_set = 1'b1;
                    end else begin
                        w_start     = 1'b1;
                        w_state_nxt = ST_DIV;
                    end
                end
            end
            ST_DIV: begin
                if (w_div_done) begin
                    w_shadow_ld = 1'b1;
                    w_err_set   = w_sat;
                    w_state_nxt = ST_PEND;
                end
            end
            ST_PEND: begin
                // Commit of the old shadow and start of a new division may coincide.
                if (w_vs_rise) begin
                    w_commit    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
                if (w_xfer) begin
                    if (w_zero) begin
                        w_err_set = 1'b1;
                    end else begin
                        w_start     = 1'b1;
                        w_state_nxt = ST_DIV;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scale_step   <= STEP_WIDTH'(DEFAULT_STEP);
            r_shadow     <= STEP_WIDTH'(DEFAULT_STEP);
            r_req_dst    <= '0;
            r_active_dst <= '0;
            r_vs         <= 1'b0;
            applied_o    <= 1'b0;
            cfg_err_o    <= 1'b0;
        end else begin
            r_vs      <= vs_i;
            applied_o <= w_commit;
            cfg_err_o <= w_err_set;
            if (w_start) begin
                r_req_dst <= cfg_dst_width;
            end
            if (w_shadow_ld) begin
                r_shadow <= w_sat ? '1 : w_div_quot[STEP_WIDTH-1:0];
            end
            if (w_commit) begin
                scale_step   <= r_shadow;
                r_active_dst <= r_req_dst;
            end
        end
    end

    assign w_diff = (r_px_cnt >= r_active_dst) ? (r_px_cnt - r_active_dst)
                                               : (r_active_dst - r_px_cnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hs           <= 1'b0;
            r_px_cnt       <= '0;
            line_len_o     <= '0;
            len_mismatch_o <= 1'b0;
        end else begin
            r_hs           <= hs_s;
            len_mismatch_o <= 1'b0;
            if (w_hs_rise && (r_px_cnt != '0)) begin
                line_len_o     <= r_px_cnt;
                // A de_s coincident with the hsync edge belongs to the next line.
                r_px_cnt       <= de_s ? WIDTH_BITS'(1) : '0;
                len_mismatch_o <= (r_active_dst != '0) && (w_diff > WIDTH_BITS'(LEN_TOL));
            end else if (de_s && (r_px_cnt != '1)) begin
                r_px_cnt <= r_px_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_scaler_h_ctrl.sv
module tb_scaler_h_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [11:0] cfg_src_width = '0;
    logic [11:0] cfg_dst_width = '0;
    logic        vs_i = 1'b0;
    logic        hs_s = 1'b0;
    logic        de_s = 1'b0;
    logic [15:0] scale_step;
    logic        busy_o;
    logic        pending_o;
    logic        applied_o;
    logic        cfg_err_o;
    logic [11:0] line_len_o;
    logic        len_mismatch_o;

    int total = 0;
    int bad   = 0;

    // Reference state: what the scaler should currently be using.
    int exp_step       = 4096;
    int exp_active_dst = 0;

    always #5 clk = ~clk;

    scaler_h_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_src_width  (cfg_src_width),
        .cfg_dst_width  (cfg_dst_width),
        .vs_i           (vs_i),
        .hs_s           (hs_s),
        .de_s           (de_s),
        .scale_step     (scale_step),
        .busy_o         (busy_o),
        .pending_o      (pending_o),
        .applied_o      (applied_o),
        .cfg_err_o      (cfg_err_o),
        .line_len_o     (line_len_o),
        .len_mismatch_o (len_mismatch_o)
    );

    // Step = round(src * 4096 / dst), clamped to 16 bits.
    function automatic int ref_step(input int src, input int dst);
        longint q;
        q = ((longint'(src) * 4096) + (dst / 2)) / dst;
        return (q > 65535) ? 65535 : int'(q);
    endfunction

    function automatic bit ref_sat(input int src, input int dst);
        longint q;
        q = ((longint'(src) * 4096) + (dst / 2)) / dst;
        return q > 65535;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cfg(input int src, input int dst);
        cfg_src_width = 12'(src);
        cfg_dst_width = 12'(dst);
        cfg_valid     = 1'b1;
        tick();
        cfg_valid     = 1'b0;
    endtask

    // Called in cycle 1 after the accepting edge; n ends at the cycle pending_o is seen.
    task automatic wait_pending(output int n, output int nerr);
        n    = 1;
        nerr = int'(cfg_err_o);
        while (pending_o !== 1'b1 && n < 100) begin
            tick();
            n++;
            nerr += int'(cfg_err_o);
        end
    endtask

    task automatic vs_pulse(output logic appl, output logic [15:0] step);
        vs_i = 1'b1;
        tick();
        appl = applied_o;
        step = scale_step;
        vs_i = 1'b0;
        tick();
    endtask

    task automatic drive_line(input int nde, output logic [11:0] len, output logic mism);
        de_s = 1'b1;
        repeat (nde) tick();
        de_s = 1'b0;
        hs_s = 1'b1;
        tick();
        len  = line_len_o;
        mism = len_mismatch_o;
        hs_s = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        total++; if (scale_step !== 16'd4096) begin bad++; $display("FAIL reset_step: got %0d expected 4096", scale_step); end
        total++; if ({busy_o, pending_o, applied_o, cfg_err_o, len_mismatch_o} !== 5'b0) begin bad++; $display("FAIL reset_flags: got %b expected 00000", {busy_o, pending_o, applied_o, cfg_err_o, len_mismatch_o}); end
        total++; if (line_len_o !== 12'd0) begin bad++; $display("FAIL reset_line_len: got %0d expected 0", line_len_o); end
        total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b expected 1", cfg_ready); end
    endtask

    task automatic test_basic();
        int n, nerr;
        logic appl;
        logic [15:0] st;
        send_cfg(1920, 1280);
        total++; if (busy_o !== 1'b1 || cfg_ready !== 1'b0) begin bad++; $display("FAIL basic_busy: got busy=%b ready=%b expected busy=1 ready=0", busy_o, cfg_ready); end
        wait_pending(n, nerr);
        total++; if (n != 25) begin bad++; $display("FAIL basic_latency: got %0d expected 25", n); end
        total++; if (nerr != 0) begin bad++; $display("FAIL basic_err: got %0d expected 0", nerr); end
        repeat (3) tick();
        total++; if (scale_step !== 16'(exp_step)) begin bad++; $display("FAIL basic_hold: got %0d expected %0d", scale_step, exp_step); end
        vs_pulse(appl, st);
        exp_step = ref_step(1920, 1280);
        exp_active_dst = 1280;
        total++; if (st !== 16'(exp_step) || appl !== 1'b1) begin bad++; $display("FAIL basic_commit: got step=%0d applied=%b expected step=%0d applied=1", st, appl, exp_step); end
        total++; if (applied_o !== 1'b0 || pending_o !== 1'b0) begin bad++; $display("FAIL basic_pulse_width: got applied=%b pending=%b expected 0 0", applied_o, pending_o); end
    endtask

    task automatic test_upscale();
        int n, nerr;
        logic appl;
        logic [15:0] st;
        send_cfg(1280, 1920);
        wait_pending(n, nerr);
        total++; if (nerr != 0 || n != 25) begin bad++; $display("FAIL upscale_div: got n=%0d err=%0d expected n=25 err=0", n, nerr); end
        vs_pulse(appl, st);
        exp_step = ref_step(1280, 1920);
        exp_active_dst = 1920;
        total++; if (st !== 16'(exp_step) || appl !== 1'b1) begin bad++; $display("FAIL upscale_commit: got %0d expected %0d", st, exp_step); end
    endtask

    task automatic test_saturate_and_zero();
        int n, nerr;
        logic appl;
        logic [15:0] st;
        send_cfg(4095, 1);
        wait_pending(n, nerr);
        total++; if (nerr != 1 || cfg_err_o !== 1'b1) begin bad++; $display("FAIL sat_err: got count=%0d now=%b expected count=1 now=1", nerr, cfg_err_o); end
        vs_pulse(appl, st);
        exp_step = ref_step(4095, 1);
        exp_active_dst = 1;
        total++; if (st !== 16'(exp_step)) begin bad++; $display("FAIL sat_commit: got %0d expected %0d", st, exp_step); end
        send_cfg(1000, 0);
        total++; if (cfg_err_o !== 1'b1 || cfg_ready !== 1'b1 || busy_o !== 1'b0) begin bad++; $display("FAIL zero_dst: got err=%b ready=%b busy=%b expected 1 1 0", cfg_err_o, cfg_ready, busy_o); end
        tick();
        total++; if (cfg_err_o !== 1'b0 || scale_step !== 16'(exp_step)) begin bad++; $display("FAIL zero_after: got err=%b step=%0d expected err=0 step=%0d", cfg_err_o, scale_step, exp_step); end
        send_cfg(0, 500);
        total++; if (cfg_err_o !== 1'b1 || busy_o !== 1'b0) begin bad++; $display("FAIL zero_src: got err=%b busy=%b expected 1 0", cfg_err_o, busy_o); end
        tick();
    endtask

    task automatic test_back_to_back();
        int n, nerr;
        logic appl;
        logic [15:0] st;
        send_cfg(1920, 1280);
        wait_pending(n, nerr);
        cfg_src_width = 12'd1280;
        cfg_dst_width = 12'd1920;
        cfg_valid     = 1'b1;
        vs_i          = 1'b1;
        tick();
        cfg_valid = 1'b0;
        vs_i      = 1'b0;
        exp_step = ref_step(1920, 1280);
        exp_active_dst = 1280;
        total++; if (applied_o !== 1'b1 || scale_step !== 16'(exp_step) || busy_o !== 1'b1) begin bad++; $display("FAIL b2b_same_cycle: got applied=%b step=%0d busy=%b expected 1 %0d 1", applied_o, scale_step, busy_o, exp_step); end
        wait_pending(n, nerr);
        total++; if (n != 25) begin bad++; $display("FAIL b2b_latency: got %0d expected 25", n); end
        vs_pulse(appl, st);
        exp_step = ref_step(1280, 1920);
        exp_active_dst = 1920;
        total++; if (st !== 16'(exp_step) || appl !== 1'b1) begin bad++; $display("FAIL b2b_second: got %0d expected %0d", st, exp_step); end
    endtask

    task automatic test_vs_during_div();
        int n, nerr;
        logic appl;
        logic [15:0] st;
        send_cfg(640, 1000);
        repeat (5) tick();
        vs_i = 1'b1;
        tick();
        total++; if (applied_o !== 1'b0 || scale_step !== 16'(exp_step)) begin bad++; $display("FAIL vs_in_div: got applied=%b step=%0d expected 0 %0d", applied_o, scale_step, exp_step); end
        vs_i = 1'b0;
        wait_pending(n, nerr);
        vs_pulse(appl, st);
        exp_step = ref_step(640, 1000);
        exp_active_dst = 1000;
        total++; if (st !== 16'(exp_step) || appl !== 1'b1) begin bad++; $display("FAIL vs_after_div: got %0d expected %0d", st, exp_step); end
    endtask

    task automatic test_random();
        int n, nerr, src, dst;
        logic appl;
        logic [15:0] st;
        for (int i = 0; i < 8; i++) begin
            src = int'($urandom_range(1, 4095));
            dst = (i == 0) ? 3 : int'($urandom_range(1, 4095));
            send_cfg(src, dst);
            wait_pending(n, nerr);
            total++; if (n != 25 || nerr != int'(ref_sat(src, dst))) begin bad++; $display("FAIL rand_div %0d/%0d: got n=%0d err=%0d expected n=25 err=%0d", src, dst, n, nerr, ref_sat(src, dst)); end
            total++; if (scale_step !== 16'(exp_step)) begin bad++; $display("FAIL rand_hold: got %0d expected %0d", scale_step, exp_step); end
            vs_pulse(appl, st);
            exp_step = ref_step(src, dst);
            exp_active_dst = dst;
            total++; if (st !== 16'(exp_step) || appl !== 1'b1) begin bad++; $display("FAIL rand_commit %0d/%0d: got %0d expected %0d", src, dst, st, exp_step); end
        end
    endtask

    task automatic test_monitor();
        int n, nerr, len;
        logic appl, mism;
        logic [15:0] st;
        logic [11:0] got;
        int lens[6] = '{1279, 1270, 1281, 1282, 1280, 1278};
        send_cfg(1920, 1280);
        wait_pending(n, nerr);
        vs_pulse(appl, st);
        exp_step = ref_step(1920, 1280);
        exp_active_dst = 1280;
        for (int i = 0; i < 6; i++) begin
            drive_line(lens[i], got, mism);
            total++; if (got !== 12'(lens[i]) || mism !== ((lens[i] > exp_active_dst + 1) || (lens[i] < exp_active_dst - 1))) begin bad++; $display("FAIL line_%0d: got len=%0d mism=%b expected len=%0d", i, got, mism, lens[i]); end
        end
        for (int i = 0; i < 3; i++) begin
            len = int'($urandom_range(1270, 1290));
            drive_line(len, got, mism);
            total++; if (got !== 12'(len) || mism !== ((len > exp_active_dst + 1) || (len < exp_active_dst - 1))) begin bad++; $display("FAIL line_rand: got len=%0d mism=%b expected len=%0d", got, mism, len); end
        end
        // de_s on the hsync edge starts the next line at one.
        de_s = 1'b1;
        repeat (1280) tick();
        hs_s = 1'b1;
        tick();
        total++; if (line_len_o !== 12'd1280 || len_mismatch_o !== 1'b0) begin bad++; $display("FAIL line_overlap_a: got len=%0d mism=%b expected 1280 0", line_len_o, len_mismatch_o); end
        hs_s = 1'b0;
        repeat (1278) tick();
        de_s = 1'b0;
        hs_s = 1'b1;
        tick();
        total++; if (line_len_o !== 12'd1279 || len_mismatch_o !== 1'b0) begin bad++; $display("FAIL line_overlap_b: got len=%0d mism=%b expected 1279 0", line_len_o, len_mismatch_o); end
        hs_s = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_div();
        logic appl, mism;
        logic [15:0] st;
        logic [11:0] got;
        send_cfg(1280, 1920);
        repeat (9) tick();
        total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL rst_pre_busy: got %b expected 1", busy_o); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_step = 4096;
        exp_active_dst = 0;
        total++; if (scale_step !== 16'd4096 || busy_o !== 1'b0 || pending_o !== 1'b0 || line_len_o !== 12'd0) begin bad++; $display("FAIL rst_mid_div: got step=%0d busy=%b pend=%b len=%0d expected 4096 0 0 0", scale_step, busy_o, pending_o, line_len_o); end
        repeat (30) tick();
        vs_pulse(appl, st);
        total++; if (appl !== 1'b0 || st !== 16'd4096) begin bad++; $display("FAIL rst_no_commit: got applied=%b step=%0d expected 0 4096", appl, st); end
        drive_line(50, got, mism);
        total++; if (got !== 12'd50 || mism !== 1'b0) begin bad++; $display("FAIL rst_no_active: got len=%0d mism=%b expected 50 0", got, mism); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_upscale();
        test_saturate_and_zero();
        test_back_to_back();
        test_vs_during_div();
        test_random();
        test_monitor();
        test_reset_mid_div();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
